gps: RTL and testbench
======================

Name: gps

Overview:
- Host-facing control core of the GPS receiver.
- Receives a bit-serial host stream (tck/tdi/shift) in the clk domain and operates in one of two modes:
  - Boot mode: streams bytes into external program RAM, then releases the embedded CPU.
  - Command mode: decodes command frames into channel configuration registers.
- Also captures raw 1-bit limiter samples into an internal buffer, which the host reads back serially on tdo.

Parameters:
- PROG_AW, 11: program RAM byte-address width.
- SAMP_AW, 10: log2 of sample buffer depth in bits (1024).
- CMD_MAX, 8: maximum stored bytes per command frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- limiter  in  1  1-bit IF sample.
- tck  in  1  host serial clock, asynchronous.
- tdi  in  1  host serial data, LSB first.
- shift  in  1  high = capture/shift phase; falling edge = update.
- sel  in  2  01 = boot, 10 = command, else idle.
- tdo  out  1  serial response bit.
- hb_rdy  out  1  one-cycle pulse when a command completes.
- core_run  out  1  CPU run enable (low = CPU held in reset).
- prog_we  out  1  program RAM write strobe.
- prog_addr  out  PROG_AW  program RAM byte address.
- prog_wdata  out  8  program RAM write data.
- chan  out  8  target channel of last SetSV/SetRate.
- sv_phase  out  16  initial code phase.
- sv_prn  out  16  PRN tap select.
- rate_ca  out  32  C/A NCO rate.
- rate_lo  out  32  LO NCO rate.
- mask  out  16  channel service-request mask.
- samp_busy  out  1  sample capture in progress.

Behaviour:
- Reset: every output and internal register is 0, core_run=0, and the sample pointers are 0.
- Input synchronisation:
  - tck, tdi, shift and sel each pass through a 2-FF synchroniser.
  - A tck rise is detected on the synced signal.
  - The shift rise is the capture event; the shift fall is the update event.
- Bit reception:
  - On a tck rise while shift=1, the synced tdi is shifted into the byte register, LSB first.
  - Every 8th bit completes a byte.
  - The capture event clears the bit and byte counters.
  - A partial byte at update is discarded.
- Boot mode (sel=01):
  - The capture event sets prog_addr=0 and core_run=0.
  - Each completed byte drives prog_we high for 1 cycle with prog_wdata=byte and the current prog_addr.
  - prog_addr then increments, wrapping at 2^PROG_AW.
  - core_run rises exactly 3 clk cycles after the update event.
- Command mode (sel=10):
  - Bytes are stored at buf[0..CMD_MAX-1]; excess bytes are dropped.
  - Missing bytes read as 0.
  - On update with at least 1 byte stored, the command executes in the following cycle and hb_rdy pulses that same cycle.
  - On update with 0 bytes stored, nothing happens.
- Command decode (buf[0]):
  - 0x00 Sample: write pointer and read pointer set to 0, samp_busy=1.
  - 0x01 SetMask: mask={buf2,buf1}.
  - 0x02 SetRateCA: chan=buf1, rate_ca={buf6,buf5,buf4,buf3}.
  - 0x03 SetRateLO: same byte layout as SetRateCA, written to rate_lo.
  - 0x06 SetSV: chan=buf1, sv_phase={buf3,buf2}, sv_prn={buf5,buf4}.
  - 0x09 GetSamples: loads a 64-bit response register with sample bits rd_ptr..rd_ptr+63 (LSB = oldest), then rd_ptr+=64, wrapping modulo depth.
  - All other codes: no register change, hb_rdy still pulses.
- Sampling:
  - While samp_busy=1, each clk stores limiter at wr_ptr and increments wr_ptr.
  - When the last location (depth-1) is written, samp_busy clears.
  - A new Sample command while busy restarts capture from 0.
  - GetSamples during capture returns the current buffer contents.
- tdo and response register:
  - tdo = response register bit 0.
  - On each tck rise while shift=1 in command mode, the response register shifts right with 0 fill.
  - A response register loaded at update appears on the next capture.
- sel idle (00 or 11): bits are ignored and no writes or commands occur.
- Asserting rst mid-frame aborts the frame and restores all reset values.

Optional Feature:
- Macro GPS_LIMITER_SYNC_EN.
- Defined: limiter passes through a 2-FF synchroniser before storage, so sample latency is 2 cycles.
- Undefined: limiter is registered once.

Test Plan:
- Boot: sel=01, send bytes 0xA5, 0x3C, 0x00, then update -> prog_we pulses at addr 0, 1, 2 with matching data; core_run=1 three cycles after shift falls.
- SetSV: sel=10, frame 06 00 00 00 26 00 -> chan=0, sv_phase=0x0000, sv_prn=0x0026, one hb_rdy pulse.
- SetRateCA: frame 02 00 00 00 00 00 20 -> rate_ca=0x20000000; then SetMask frame 01 00 01 -> mask=0x0100.
- Sample/GetSamples:
  - Drive limiter with alternating 1,0 each clk, send Sample, wait until samp_busy=0, send GetSamples, then shift 64 bits -> tdo pattern alternating.
  - A second GetSamples returns bits 64..127.
- Edge cases:
  - Update with 0 bytes -> no hb_rdy.
  - 10-byte frame -> only 8 stored.
  - Unknown code 0x7F -> hb_rdy pulses with no register change.
  - 3 bits then update -> byte discarded.
- Reset mid-boot -> prog_addr=0, core_run=0, all registers 0.

Source files
------------

// File: rtl/gps_if.sv
// Host-side bus of the GPS control core: bit-serial host link plus the
// program RAM write port driven during boot.
interface gps_if #(
   parameter int PROG_AW = 11
);
   logic               tck;
   logic               tdi;
   logic               shift;
   logic [1:0]         sel;
   logic               tdo;
   logic               prog_we;
   logic [PROG_AW-1:0] prog_addr;
   logic [7:0]         prog_wdata;

   modport master (output tck, tdi, shift, sel,
                   input  tdo, prog_we, prog_addr, prog_wdata);
   modport slave  (input  tck, tdi, shift, sel,
                   output tdo, prog_we, prog_addr, prog_wdata);
endinterface

// File: rtl/gps.sv
// GPS receiver host control core: serial boot loader, command decoder and
// 1-bit sample capture buffer. Define GPS_LIMITER_SYNC_EN to double-sync limiter.
module gps #(
   parameter int PROG_AW = 11,
   parameter int SAMP_AW = 10,
   parameter int CMD_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        limiter,
   gps_if.slave        host,
   output logic        hb_rdy,
   output logic        core_run,
   output logic [7:0]  chan,
   output logic [15:0] sv_phase,
   output logic [15:0] sv_prn,
   output logic [31:0] rate_ca,
   output logic [31:0] rate_lo,
   output logic [15:0] mask,
   output logic        samp_busy
);
   localparam int DEPTH = 1 << SAMP_AW;
   localparam int CW    = $clog2(CMD_MAX + 1);
   // Byte 7 is counted but no command decodes it, so only 0..6 are kept.
   localparam int KEEP  = 7;

   logic [1:0]           tck_s, tdi_s, shift_s, sel_m, sel_s;
   logic                 tck_q, shift_q;
   logic [2:0]           bit_cnt;
   logic [6:0]           byte_sr;
   logic [CW-1:0]        byte_cnt;
   logic [KEEP-1:0][7:0] cmd_buf;
   logic [63:0]          resp;
   logic [1:0]           boot_dly;
   logic                 prog_we;
   logic [PROG_AW-1:0]   prog_addr;
   logic [7:0]           prog_wdata;
   logic [DEPTH-1:0]     samp_mem;
   logic [SAMP_AW-1:0]   wr_ptr, rd_ptr;
   logic                 lim_q;

   logic       tck_rise, capture, update, boot, cmd, bit_en;
   logic [7:0] byte_nxt;

`ifdef GPS_LIMITER_SYNC_EN
   logic [1:0] lim_s;
   always_ff @(posedge clk or posedge rst)
      if (rst) lim_s <= '0;
      else     lim_s <= {lim_s[0], limiter};
   assign lim_q = lim_s[1];
`else
   logic lim_r;
   always_ff @(posedge clk or posedge rst)
      if (rst) lim_r <= 1'b0;
      else     lim_r <= limiter;
   assign lim_q = lim_r;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tck_s   <= '0;
         tdi_s   <= '0;
         shift_s <= '0;
         sel_m   <= '0;
         sel_s   <= '0;
         tck_q   <= 1'b0;
         shift_q <= 1'b0;
      end else begin
         tck_s   <= {tck_s[0], host.tck};
         tdi_s   <= {tdi_s[0], host.tdi};
         shift_s <= {shift_s[0], host.shift};
         sel_m   <= host.sel;
         sel_s   <= sel_m;
         tck_q   <= tck_s[1];
         shift_q <= shift_s[1];
      end

   assign tck_rise = tck_s[1] & ~tck_q;
   assign capture  = shift_s[1] & ~shift_q;
   assign update   = ~shift_s[1] & shift_q;
   assign boot     = (sel_s == 2'b01);
   assign cmd      = (sel_s == 2'b10);
   assign bit_en   = tck_rise & shift_s[1] & ~capture & (boot | cmd);
   assign byte_nxt = {tdi_s[1], byte_sr};

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bit_cnt    <= '0;
         byte_sr    <= '0;
         byte_cnt   <= '0;
         cmd_buf    <= '0;
         resp       <= '0;
         boot_dly   <= '0;
         prog_we    <= 1'b0;
         prog_addr  <= '0;
         prog_wdata <= '0;
         core_run   <= 1'b0;
         hb_rdy     <= 1'b0;
         chan       <= '0;
         sv_phase   <= '0;
         sv_prn     <= '0;
         rate_ca    <= '0;
         rate_lo    <= '0;
         mask       <= '0;
         samp_busy  <= 1'b0;
         samp_mem   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         prog_we  <= 1'b0;
         hb_rdy   <= 1'b0;
         boot_dly <= {boot_dly[0], update & boot};
         if (boot_dly[1]) core_run <= 1'b1;
         // Address advances only after the write strobe has used it.
         if (prog_we) prog_addr <= prog_addr + PROG_AW'(1);

         if (capture) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            cmd_buf  <= '0;
            if (boot) begin
               prog_addr <= '0;
               core_run  <= 1'b0;
            end
         end else if (bit_en) begin
            byte_sr <= byte_nxt[7:1];
            bit_cnt <= bit_cnt + 3'd1;
            if (cmd) resp <= {1'b0, resp[63:1]};
            if (bit_cnt == 3'd7) begin
               if (boot) begin
                  prog_we    <= 1'b1;
                  prog_wdata <= byte_nxt;
               end
               if (cmd && byte_cnt < CW'(CMD_MAX)) begin
                  if (byte_cnt < CW'(KEEP)) cmd_buf[byte_cnt[2:0]] <= byte_nxt;
                  byte_cnt <= byte_cnt + CW'(1);
               end
            end
         end

         if (update && cmd && byte_cnt != '0) hb_rdy <= 1'b1;

         if (samp_busy) begin
            samp_mem[wr_ptr] <= lim_q;
            wr_ptr           <= wr_ptr + SAMP_AW'(1);
            if (wr_ptr == SAMP_AW'(DEPTH - 1)) samp_busy <= 1'b0;
         end

         // hb_rdy marks the execute cycle of the frame just closed.
         if (hb_rdy) begin
            case (cmd_buf[0])
               8'h00: begin
                  wr_ptr    <= '0;
                  rd_ptr    <= '0;
                  samp_busy <= 1'b1;
               end
               8'h01: mask <= {cmd_buf[2], cmd_buf[1]};
               8'h02: begin
                  chan    <= cmd_buf[1];
                  rate_ca <= {cmd_buf[6], cmd_buf[5], cmd_buf[4], cmd_buf[3]};
               end
               8'h03: begin
                  chan    <= cmd_buf[1];
                  rate_lo <= {cmd_buf[6], cmd_buf[5], cmd_buf[4], cmd_buf[3]};
               end
               8'h06: begin
                  chan     <= cmd_buf[1];
                  sv_phase <= {cmd_buf[3], cmd_buf[2]};
                  sv_prn   <= {cmd_buf[5], cmd_buf[4]};
               end
               8'h09: begin
                  for (int i = 0; i < 64; i++)
                     resp[i] <= samp_mem[rd_ptr + SAMP_AW'(i)];
                  rd_ptr <= rd_ptr + SAMP_AW'(64);
               end
               default: ;
            endcase
         end
      end

   assign host.tdo        = resp[0];
   assign host.prog_we    = prog_we;
   assign host.prog_addr  = prog_addr;
   assign host.prog_wdata = prog_wdata;
endmodule

// File: tb/tb_gps.sv
// Bench for gps: boot load, table-driven command frames, sample capture
// readback and random command frames against a byte-level reference model.
module tb_gps;
`ifdef GPS_LIMITER_SYNC_EN
   localparam int LIM_LAT = 2;
`else
   localparam int LIM_LAT = 1;
`endif

   logic        clk = 1'b0, rst = 1'b1, limiter = 1'b0;
   logic        hb_rdy, core_run, samp_busy;
   logic [7:0]  chan;
   logic [15:0] sv_phase, sv_prn, mask;
   logic [31:0] rate_ca, rate_lo;

   gps_if #(.PROG_AW(11)) h();

   always #5 clk = ~clk;

   gps dut (
      .clk(clk), .rst(rst), .limiter(limiter), .host(h),
      .hb_rdy(hb_rdy), .core_run(core_run), .chan(chan),
      .sv_phase(sv_phase), .sv_prn(sv_prn), .rate_ca(rate_ca),
      .rate_lo(rate_lo), .mask(mask), .samp_busy(samp_busy)
   );

   typedef struct {
      logic [1:0]  sel;
      logic [79:0] data;
      int          nbits;
      logic [7:0]  chan;
      logic [15:0] ph, prn, mask;
      logic [31:0] rca, rlo;
      int          hb;
   } vec_t;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, hb_cnt = 0, busy_start = -1, busy_len = 0;
   bit busy_prev = 0, lim_rand = 0;
   bit lim_hist [0:65535];
   logic [18:0] wq[$];

   logic [7:0]  m_chan;
   logic [15:0] m_ph, m_prn, m_mask;
   logic [31:0] m_rca, m_rlo;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitors and limiter drive, all at the negative edge.
   initial forever begin
      @(negedge clk);
      if (hb_rdy) hb_cnt++;
      if (h.prog_we) wq.push_back({h.prog_addr, h.prog_wdata});
      if (samp_busy && !busy_prev) begin busy_start = cyc; busy_len = 0; end
      if (samp_busy) busy_len++;
      busy_prev = samp_busy;
      limiter = lim_rand ? 1'($urandom_range(0, 1)) : 1'(cyc % 2 == 0);
      lim_hist[cyc % 65536] = limiter;
      cyc++;
   end

   initial begin
      #3000000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic put_bits(input logic [127:0] d, input int n, output logic [127:0] got);
      got = '0;
      for (int i = 0; i < n; i++) begin
         got[i] = h.tdo;
         h.tdi = d[i];
         clks(2); h.tck = 1'b1;
         clks(4); h.tck = 1'b0;
         clks(4);
      end
   endtask

   task automatic frame(input logic [1:0] s, input logic [127:0] d, input int n,
                        output logic [127:0] got);
      h.sel = s; clks(4);
      h.shift = 1'b1; clks(5);
      put_bits(d, n, got);
      h.shift = 1'b0; clks(8);
   endtask

   // Reference: command bytes with missing ones read as zero, excess ignored.
   task automatic model(input logic [79:0] d, input int n);
      logic [7:0] b [8];
      for (int k = 0; k < 8; k++) b[k] = (k < n) ? d[8*k +: 8] : 8'h00;
      case (b[0])
         8'h01: m_mask = {b[2], b[1]};
         8'h02: begin m_chan = b[1]; m_rca = {b[6], b[5], b[4], b[3]}; end
         8'h03: begin m_chan = b[1]; m_rlo = {b[6], b[5], b[4], b[3]}; end
         8'h06: begin m_chan = b[1]; m_ph = {b[3], b[2]}; m_prn = {b[5], b[4]}; end
         default: ;
      endcase
   endtask

   task automatic check_regs(input string t, input logic [7:0] c, input logic [15:0] p,
                             input logic [15:0] r, input logic [15:0] m,
                             input logic [31:0] ca, input logic [31:0] lo);
      chk({t, "_chan"}, chan, c);
      chk({t, "_phase"}, sv_phase, p);
      chk({t, "_prn"}, sv_prn, r);
      chk({t, "_mask"}, mask, m);
      chk({t, "_rate_ca"}, rate_ca, ca);
      chk({t, "_rate_lo"}, rate_lo, lo);
   endtask

   initial begin
      vec_t tv [10];
      logic [127:0] got, expw;
      logic [7:0]   bd [3];
      int h0, t, base, n, r;
      logic [79:0]  d;
      logic [7:0]   code;

      tv[0] = '{2'b10, 80'h002600000006, 48, 8'h00, 16'h0000, 16'h0026, 16'h0000, 32'h0, 32'h0, 1};
      tv[1] = '{2'b10, 80'h20000000000002, 56, 8'h00, 16'h0000, 16'h0026, 16'h0000, 32'h20000000, 32'h0, 1};
      tv[2] = '{2'b10, 80'h010001, 24, 8'h00, 16'h0000, 16'h0026, 16'h0100, 32'h20000000, 32'h0, 1};
      tv[3] = '{2'b10, 80'h44332211000503, 56, 8'h05, 16'h0000, 16'h0026, 16'h0100, 32'h20000000, 32'h44332211, 1};
      tv[4] = '{2'b10, 80'hFF01BBAA567812340706, 80, 8'h07, 16'h1234, 16'h5678, 16'h0100, 32'h20000000, 32'h44332211, 1};
      tv[5] = '{2'b10, 80'h0605040302017F, 56, 8'h07, 16'h1234, 16'h5678, 16'h0100, 32'h20000000, 32'h44332211, 1};
      tv[6] = '{2'b10, 80'h0, 0, 8'h07, 16'h1234, 16'h5678, 16'h0100, 32'h20000000, 32'h44332211, 0};
      tv[7] = '{2'b10, 80'h3, 3, 8'h07, 16'h1234, 16'h5678, 16'h0100, 32'h20000000, 32'h44332211, 0};
      tv[8] = '{2'b10, 80'h0902, 16, 8'h09, 16'h1234, 16'h5678, 16'h0100, 32'h0, 32'h44332211, 1};
      tv[9] = '{2'b00, 80'hFFFF01, 24, 8'h09, 16'h1234, 16'h5678, 16'h0100, 32'h0, 32'h44332211, 0};

      h.tck = 0; h.tdi = 0; h.shift = 0; h.sel = 2'b00;
      clks(3);
      chk("rst_core_run", core_run, 0);
      chk("rst_prog_addr", h.prog_addr, 0);
      chk("rst_tdo", h.tdo, 0);
      chk("rst_busy", samp_busy, 0);
      check_regs("rst", 0, 0, 0, 0, 0, 0);
      rst = 1'b0; clks(2);

      // Boot load of three bytes, then release timing relative to raw shift fall.
      wq.delete();
      bd[0] = 8'hA5; bd[1] = 8'h3C; bd[2] = 8'h00;
      h.sel = 2'b01; clks(4);
      h.shift = 1'b1; clks(5);
      chk("boot_cap_addr", h.prog_addr, 0);
      put_bits(128'h003CA5, 24, got);
      h.shift = 1'b0;
      clks(4); chk("boot_run_early", core_run, 0);   // 2 sync stages + 3 cycles
      clks(1); chk("boot_run", core_run, 1);
      chk("boot_nwr", wq.size(), 3);
      for (int i = 0; i < 3 && i < wq.size(); i++)
         chk($sformatf("boot_wr%0d", i), wq[i], {11'(i), bd[i]});
      chk("boot_addr_end", h.prog_addr, 3);
      chk("boot_hb", hb_cnt, 0);

      for (int v = 0; v < 10; v++) begin
         h0 = hb_cnt;
         frame(tv[v].sel, {48'h0, tv[v].data}, tv[v].nbits, got);
         chk($sformatf("v%0d_hb", v), hb_cnt - h0, tv[v].hb);
         check_regs($sformatf("v%0d", v), tv[v].chan, tv[v].ph, tv[v].prn, tv[v].mask,
                    tv[v].rca, tv[v].rlo);
      end
      m_chan = tv[9].chan; m_ph = tv[9].ph; m_prn = tv[9].prn;
      m_mask = tv[9].mask; m_rca = tv[9].rca; m_rlo = tv[9].rlo;

      // Capture (alternating, then random limiter) and two GetSamples windows.
      for (int run = 0; run < 2; run++) begin
         lim_rand = (run == 1);
         busy_start = -1;
         frame(2'b10, 128'h00, 8, got);
         t = 0;
         while (samp_busy && t < 3000) begin clks(1); t++; end
         chk($sformatf("s%0d_done", run), t < 3000, 1);
         chk($sformatf("s%0d_len", run), busy_len, 1024);
         base = busy_start - LIM_LAT;
         if (base < 0) base = 0;
         for (int i = 0; i < 128; i++) expw[i] = lim_hist[(base + i) % 65536];
         frame(2'b10, 128'h09, 8, got);
         frame(2'b10, {72'h0, 56'hFFFFFFFFFFFFFF, 8'h09}, 64, got);
         chk($sformatf("s%0d_win0", run), got[63:0], expw[63:0]);
         frame(2'b10, {128{1'b1}}, 64, got);
         chk($sformatf("s%0d_win1", run), got[63:0], expw[127:64]);
      end
      check_regs("post_samp", m_chan, m_ph, m_prn, m_mask, m_rca, m_rlo);

      for (int f = 0; f < 24; f++) begin
         n = $urandom_range(1, 10);
         r = $urandom_range(0, 5);
         d = {16'($urandom), $urandom, $urandom};
         case (r)
            0: code = 8'h01;
            1: code = 8'h02;
            2: code = 8'h03;
            3: code = 8'h06;
            default: begin
               code = 8'($urandom);
               if (code == 8'h00 || code == 8'h09) code = 8'h7F;
            end
         endcase
         d[7:0] = code;
         for (int k = 0; k < 10; k++) if (k >= n) d[8*k +: 8] = 8'h00;
         model(d, n);
         h0 = hb_cnt;
         frame(2'b10, {48'h0, d}, 8 * n, got);
         chk($sformatf("r%0d_hb", f), hb_cnt - h0, 1);
         check_regs($sformatf("r%0d", f), m_chan, m_ph, m_prn, m_mask, m_rca, m_rlo);
      end

      // Reset in the middle of a boot frame.
      h.sel = 2'b01; clks(4);
      h.shift = 1'b1; clks(5);
      put_bits(128'h5C3, 12, got);
      chk("mid_addr", h.prog_addr, 1);
      chk("mid_run", core_run, 0);
      rst = 1'b1; clks(2);
      chk("mrst_addr", h.prog_addr, 0);
      chk("mrst_we", h.prog_we, 0);
      chk("mrst_tdo", h.tdo, 0);
      chk("mrst_hb", hb_rdy, 0);
      chk("mrst_busy", samp_busy, 0);
      check_regs("mrst", 0, 0, 0, 0, 0, 0);
      h.shift = 1'b0; h.tck = 1'b0; clks(2);
      rst = 1'b0; clks(10);
      chk("mrst_run_after", core_run, 0);
      chk("mrst_addr_after", h.prog_addr, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
